ysyx_22051013_ifu_fetch: RTL and testbench

Instruction fetch stage directly upstream of the decode stage.
- Owns the PC and issues in-order word fetches to the instruction memory port.
- Buffers returned instructions in a small FIFO and presents {inst, pc} to decode with a valid/ready handshake.
- Handles redirects (taken branch / jal / jalr / trap) from execute by flushing buffered and in-flight fetches.

---
 rtl/ysyx_22051013_ifu_fetch_if.sv | 33 +++
 rtl/ysyx_22051013_ifu_fetch.sv | 124 ++++++++++++
 tb/tb_ysyx_22051013_ifu_fetch.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect
// and the decode handshake. The master modport is the fetch unit's view.
interface ysyx_22051013_ifu_fetch_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    input  id_ready,
    output id_valid, id_inst, id_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    output id_ready,
    input  id_valid, id_inst, id_pc
  );
endinterface

// File: rtl/ysyx_22051013_ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches, buffers
// responses for decode and flushes on redirect. Optional perf counters: IFU_PERF_CNT_EN.
module ysyx_22051013_ifu_fetch #(
  parameter int unsigned      XLEN       = 64,
  parameter logic [XLEN-1:0]  PC_RESET   = 64'h0000_0000_8000_0000,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22051013_ifu_fetch_if.master     bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]                   perf_fetch_cnt,
  output logic [63:0]                   perf_bubble_cnt
`endif
);

  localparam int unsigned     PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned     CNT_W     = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0]     NOP_INST  = 32'h0000_0013;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [XLEN-1:0] pc_reg;
  logic [31:0]     inst_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] req_pc_q [FIFO_DEPTH];
  ptr_t            fifo_wr_ptr, fifo_rd_ptr, pcq_wr_ptr, pcq_rd_ptr;
  cnt_t            fifo_count, outstanding, discard_cnt;
  logic [XLEN-1:0] id_pc_hold;

  logic            fifo_empty, req_valid, req_fire, id_valid, id_fire, resp_push;
  logic [CNT_W:0]  credit_used;
  logic [XLEN-1:0] id_pc;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    fifo_empty  = (fifo_count == '0);
    credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    // Credit covers responses still to be discarded, so the buffer never overflows.
    req_valid   = ~rst & ~bus.redirect_valid & (credit_used < DEPTH_LIM);
    req_fire    = req_valid & bus.imem_req_ready;
    id_valid    = ~rst & ~fifo_empty & ~bus.redirect_valid;
    id_fire     = id_valid & bus.id_ready;
    resp_push   = ~rst & bus.imem_resp_valid & ~bus.redirect_valid & (discard_cnt == '0);
    id_pc       = fifo_empty ? id_pc_hold : pc_mem[fifo_rd_ptr];
    if (rst) id_pc = '0;

    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = pc_reg;
    bus.id_valid       = id_valid;
    bus.id_inst        = (rst | fifo_empty) ? NOP_INST : inst_mem[fifo_rd_ptr];
    bus.id_pc          = id_pc;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= PC_RESET;
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      pcq_wr_ptr  <= '0;
      pcq_rd_ptr  <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else if (bus.redirect_valid) begin
      pc_reg      <= bus.redirect_pc;
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      pcq_wr_ptr  <= '0;
      pcq_rd_ptr  <= '0;
      fifo_count  <= '0;
      // Everything still in flight, including earlier pending discards, is stale.
      outstanding <= outstanding - cnt_t'(bus.imem_resp_valid);
      discard_cnt <= outstanding - cnt_t'(bus.imem_resp_valid);
    end else begin
      if (req_fire) begin
        pc_reg     <= pc_reg + XLEN'(4);
        pcq_wr_ptr <= pcq_wr_ptr + ptr_t'(1);
      end
      outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(bus.imem_resp_valid);
      if (bus.imem_resp_valid && discard_cnt != '0) discard_cnt <= discard_cnt - cnt_t'(1);
      if (resp_push) begin
        fifo_wr_ptr <= fifo_wr_ptr + ptr_t'(1);
        pcq_rd_ptr  <= pcq_rd_ptr + ptr_t'(1);
      end
      if (id_fire) fifo_rd_ptr <= fifo_rd_ptr + ptr_t'(1);
      fifo_count <= fifo_count + cnt_t'(resp_push) - cnt_t'(id_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) id_pc_hold <= '0;
    else     id_pc_hold <= id_pc;
  end

  // NOTE: the storage arrays carry no reset; pointers and counts reset, so stale
  // contents are never observable and the arrays can map to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (req_fire) req_pc_q[pcq_wr_ptr] <= pc_reg;
    if (resp_push) begin
      inst_mem[fifo_wr_ptr] <= bus.imem_resp_data;
      pc_mem[fifo_wr_ptr]   <= req_pc_q[pcq_rd_ptr];
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (id_fire) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (bus.id_ready && !id_valid) perf_bubble_cnt <= perf_bubble_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22051013_ifu_fetch.sv
// Bench for ysyx_22051013_ifu_fetch: 1-cycle memory model with stall/hold knobs,
// scoreboard of expected {inst, pc} popped by an independent decode-side monitor.
module tb_ysyx_22051013_ifu_fetch;
  localparam int          XLEN = 64;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  ysyx_22051013_ifu_fetch_if #(.XLEN(XLEN)) bus ();
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

  ysyx_22051013_ifu_fetch #(
    .XLEN(XLEN), .PC_RESET(64'h0000_0000_8000_0000), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int          total = 0, bad = 0;
  int          cyc = 0, pops = 0, req_cnt = 0;
  int          first_req_cyc = -1, first_valid_cyc = -1;
  int          m_fires = 0, m_bubbles = 0;
  logic [63:0] first_req_addr = '0, last_fire_pc = '0, mem_a;
  bit          mem_stall = 0, resp_hold = 0;
  exp_t        sb[$];
  logic [63:0] pend[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0003;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_stream(input logic [63:0] start, input int n);
    exp_t e;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      e.pc   = start + 64'(4 * i);
      e.inst = mem_word(e.pc);
      sb.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: responds in order one cycle after the request fires.
  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) pend.delete();
      if (!resp_hold && !rst && pend.size() > 0) begin
        mem_a               = pend.pop_front();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_word(mem_a);
      end else begin
        bus.imem_resp_valid = 1'b0;
      end
      bus.imem_req_ready = !mem_stall;
      #1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend.push_back(bus.imem_req_addr);
        req_cnt++;
        if (first_req_cyc < 0) begin
          first_req_cyc  = cyc;
          first_req_addr = bus.imem_req_addr;
        end
      end
    end
  end

  // Decode-side monitor: pops the scoreboard on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        m_fires   = 0;
        m_bubbles = 0;
      end else if (bus.id_ready && !bus.id_valid) begin
        m_bubbles++;
      end
      if (bus.redirect_valid && !rst) check("id_valid_in_redirect", 64'(bus.id_valid), 64'd0);
      if (bus.id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.id_valid && bus.id_ready) begin
        pops++;
        m_fires++;
        last_fire_pc = bus.id_pc;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_id: got pc %h, expected nothing", bus.id_pc);
        end else begin
          e = sb.pop_front();
          check("id_pc", bus.id_pc, e.pc);
          check("id_inst", 64'(bus.id_inst), 64'(e.inst));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          p0, base;
    logic [63:0] a0;
    rst                = 1'b1;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset outputs
    step(2);
    #3;
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_id_valid", 64'(bus.id_valid), 64'd0);
    check("rst_id_inst", 64'(bus.id_inst), 64'(NOP));
    check("rst_id_pc", bus.id_pc, 64'd0);

    // Streaming from reset
    @(negedge clk);
    expect_stream(64'h8000_0000, 64);
    first_req_cyc   = -1;
    first_valid_cyc = -1;
    rst             = 1'b0;
    bus.id_ready    = 1'b1;
    p0              = pops;
    step(20);
    check("first_req_addr", first_req_addr, 64'h8000_0000);
    check("first_valid_latency", 64'(first_valid_cyc - first_req_cyc), 64'd2);
    check("stream_progress", 64'(pops - p0 >= 10), 64'd1);

    // Memory not ready: address holds, nothing issued, output drains
    mem_stall = 1'b1;
    base      = req_cnt;
    #3;
    a0 = bus.imem_req_addr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      check("addr_stable", bus.imem_req_addr, a0);
    end
    check("no_req_not_ready", 64'(req_cnt - base), 64'd0);
    check("empty_id_valid", 64'(bus.id_valid), 64'd0);
    check("empty_id_inst", 64'(bus.id_inst), 64'(NOP));
    check("empty_id_pc_hold", bus.id_pc, last_fire_pc);
    @(negedge clk);
    mem_stall = 1'b0;
    p0        = pops;
    step(20);
    check("resume_progress", 64'(pops - p0 >= 8), 64'd1);

    // Mid-operation reset, then decode stall fills the buffer
    rst          = 1'b1;
    bus.id_ready = 1'b0;
    step(2);
    #3;
    check("midrst_id_valid", 64'(bus.id_valid), 64'd0);
    check("midrst_id_pc", bus.id_pc, 64'd0);
    @(negedge clk);
    expect_stream(64'h8000_0000, 32);
    rst  = 1'b0;
    base = req_cnt;
    step(10);
    check("credit_req_count", 64'(req_cnt - base), 64'd2);
    #3;
    check("full_no_req", 64'(bus.imem_req_valid), 64'd0);
    @(negedge clk);
    bus.id_ready = 1'b1;
    p0           = pops;
    step(2);
    check("full_drain_pops", 64'(pops - p0), 64'd2);
    step(10);

    // Redirect while the buffer is full
    bus.id_ready = 1'b0;
    step(6);
    expect_stream(64'h8000_2000, 32);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_2000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b1;
    p0                 = pops;
    step(20);
    check("redirect_full_progress", 64'(pops - p0 >= 8), 64'd1);

    // Redirect with two requests outstanding
    rst          = 1'b1;
    bus.id_ready = 1'b0;
    resp_hold    = 1'b1;
    step(2);
    rst  = 1'b0;
    base = req_cnt;
    step(3);
    check("two_outstanding", 64'(req_cnt - base), 64'd2);
    expect_stream(64'h8000_1000, 32);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    resp_hold          = 1'b0;
    bus.id_ready       = 1'b1;
    p0                 = pops;
    step(20);
    check("redirect_2_progress", 64'(pops - p0 >= 8), 64'd1);

    // Back-to-back redirects with one request in flight
    rst          = 1'b1;
    bus.id_ready = 1'b0;
    resp_hold    = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    expect_stream(64'h100, 32);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    @(negedge clk);
    expect_stream(64'h200, 32);
    bus.redirect_pc = 64'h200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    resp_hold          = 1'b0;
    bus.id_ready       = 1'b1;
    p0                 = pops;
    step(20);
    check("redirect_b2b_progress", 64'(pops - p0 >= 8), 64'd1);

`ifdef IFU_PERF_CNT_EN
    // Counters: 8 fetches; bubbles at cycles 0,1,4,7,10 after release
    rst          = 1'b1;
    bus.id_ready = 1'b0;
    step(2);
    expect_stream(64'h8000_0000, 32);
    rst          = 1'b0;
    bus.id_ready = 1'b1;
    p0           = pops;
    for (int i = 0; i < 100 && (pops - p0) < 8; i++) @(negedge clk);
    bus.id_ready = 1'b0;
    #3;
    check("perf_fetch_8", perf_fetch_cnt, 64'd8);
    check("perf_bubble_5", perf_bubble_cnt, 64'd5);
    @(negedge clk);
    mem_stall    = 1'b1;
    bus.id_ready = 1'b1;
    step(6);
    mem_stall = 1'b0;
    step(4);
    #3;
    check("perf_fetch_model", perf_fetch_cnt, 64'(m_fires));
    check("perf_bubble_model", perf_bubble_cnt, 64'(m_bubbles));
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
